// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: single-outstanding fetch over a valid/ready memory port,
// a small instruction FIFO toward decode, redirect flush and ebreak halt.
//
//   state  | meaning
//   IDLE   | no request outstanding; issue when a FIFO slot is guaranteed
//   REQ    | mem_req_valid asserted, address held until accepted
//   WAIT   | request accepted, waiting for its single response
module ysyx_22050612_ifu #(
   parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        mem_req_valid,
   output logic [63:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   input  logic        inst_ready,
   output logic        halted
);

   localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [31:0] EBREAK  = 32'h0010_0073;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] addr_q, addr_d;
   logic        drop_q, drop_d;
   logic        halted_q, halted_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count;
   logic        push, pop;

   logic [31:0] data_q  [FIFO_DEPTH];
   logic [63:0] pcbuf_q [FIFO_DEPTH];

   assign count         = wr_ptr_q - rd_ptr_q;
   assign inst_valid    = (count != '0);
   assign inst          = data_q[rd_ptr_q[AW-1:0]];
   assign inst_pc       = pcbuf_q[rd_ptr_q[AW-1:0]];
   assign mem_req_valid = (state_q == S_REQ);
   assign mem_req_addr  = addr_q;
   assign halted        = halted_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      drop_d   = drop_q;
      halted_d = halted_q;
      push     = 1'b0;
      pop      = inst_valid && inst_ready && !redirect_valid;

      unique case (state_q)
         S_IDLE: begin
            // Only one request in flight, so a free slot now is a slot at response time.
            if (!halted_q && (count != DEPTH_C)) begin
               state_d = S_REQ;
               addr_d  = pc_q;
            end
         end
         S_REQ: begin
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               state_d = S_IDLE;
               if (drop_q) begin
                  drop_d = 1'b0;
               end else begin
                  push = 1'b1;
                  pc_d = pc_q + 64'd4;
                  if (mem_rsp_data == EBREAK) halted_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (redirect_valid) begin
         push     = 1'b0;
         pc_d     = redirect_pc & ~64'd3;
         halted_d = 1'b0;
         unique case (state_q)
            S_IDLE:  begin
               state_d = S_IDLE;
               addr_d  = addr_q;
            end
            S_REQ:   drop_d = 1'b1;
            // A response landing with the redirect is the stale one itself.
            S_WAIT:  drop_d = !mem_rsp_valid;
            default: drop_d = 1'b0;
         endcase
      end

      wr_ptr_d = redirect_valid ? '0 : wr_ptr_q + (AW+1)'(push);
      rd_ptr_d = redirect_valid ? '0 : rd_ptr_q + (AW+1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         drop_q   <= 1'b0;
         halted_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i]  <= '0;
            pcbuf_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         drop_q   <= drop_d;
         halted_q <= halted_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push) begin
            data_q[wr_ptr_q[AW-1:0]]  <= mem_rsp_data;
            pcbuf_q[wr_ptr_q[AW-1:0]] <= pc_q;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Scoreboard bench for the fetch unit: a behavioural memory plus an in-order
// expected-instruction queue, with randomized handshakes and redirects.
module tb_ysyx_22050612_ifu;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk, rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        mem_req_valid, mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid, inst_ready, halted;
   logic [31:0] inst;
   logic [63:0] inst_pc;

   ysyx_22050612_ifu #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] w;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0, errors = 0;
   int          pops = 0, buffered = 0;
   logic        run = 1'b0;

   // reference state: next PC to fetch, halt flag, outstanding memory transaction
   logic [63:0] fetch_pc, ebreak_addr, pend_addr, prev_addr, force_tgt;
   logic        model_halted, pending, pend_stale, req_stale, prev_waiting;
   logic        chk_valid, chk_flush, chk_halt, first_chk, force_redir, redir_on_rsp;
   int          pend_delay;
   int          p_ready, p_iready, p_redir, max_delay;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == ebreak_addr) return EBREAK;
      return {a[26:2] ^ a[51:27], 7'b0010011};
   endfunction

   function automatic logic [63:0] rand_target();
      if ($urandom_range(9) == 0) return 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(3));
      return 64'h8000_0000 + 64'($urandom_range(255));
   endfunction

   task automatic apply_reset();
      run = 1'b0;
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
      fetch_pc = RESET_PC; model_halted = 1'b0; pending = 1'b0; pend_stale = 1'b0;
      req_stale = 1'b0; prev_waiting = 1'b0; chk_valid = 1'b0; chk_flush = 1'b0;
      chk_halt = 1'b0; force_redir = 1'b0; pops = 0; buffered = 0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_addr", mem_req_addr, RESET_PC);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_halted", halted, 0);
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;
      first_chk = 1'b1;
   endtask

   // One clock: check what the last edge produced, then drive inputs for the next edge.
   task automatic step();
      logic        hs, redir, do_rsp;
      logic [63:0] tgt;
      exp_t        e;
      @(posedge clk);
      #1;
      if (first_chk) begin
         check("first_req_valid", mem_req_valid, 1);
         check("first_req_addr", mem_req_addr, RESET_PC);
         first_chk = 1'b0;
      end
      if (chk_valid) check("rsp_to_inst_valid", inst_valid, 1);
      if (chk_flush) begin
         check("redir_flush_valid", inst_valid, 0);
         check("redir_clr_halted", halted, 0);
      end
      if (chk_halt) check("halted_set", halted, 1);
      if (model_halted) check("halted_no_req", mem_req_valid, 0);
      if (prev_waiting) begin
         check("req_hold_valid", mem_req_valid, 1);
         check("req_hold_addr", mem_req_addr, prev_addr);
      end
      chk_valid = 1'b0; chk_flush = 1'b0; chk_halt = 1'b0;

      do_rsp = pending && (pend_delay == 0);
      redir  = force_redir || ($urandom_range(99) < p_redir) || (redir_on_rsp && do_rsp);
      tgt    = force_redir ? force_tgt : rand_target();
      force_redir = 1'b0;

      mem_rsp_valid = do_rsp;
      mem_rsp_data  = do_rsp ? mem_word(pend_addr) : $urandom;
      if (do_rsp) begin
         pending = 1'b0;
         if (!pend_stale && !redir) begin
            e.pc = pend_addr;
            e.w  = mem_word(pend_addr);
            exp_q.push_back(e);
            buffered++;
            check("fifo_bound", (buffered <= DEPTH), 1);
            chk_valid = 1'b1;
            if (e.w == EBREAK) begin
               model_halted = 1'b1;
               chk_halt = 1'b1;
            end
         end
      end else if (pending) begin
         pend_delay--;
      end

      mem_req_ready = ($urandom_range(99) < p_ready);
      hs = mem_req_valid && mem_req_ready;
      if (hs) begin
         check("one_outstanding", pending, 0);
         if (!req_stale) begin
            check("req_addr", mem_req_addr, fetch_pc);
            check("req_while_halted", model_halted, 0);
            fetch_pc = fetch_pc + 64'd4;
         end
         pending    = 1'b1;
         pend_addr  = mem_req_addr;
         pend_stale = req_stale;
         pend_delay = int'($urandom_range(max_delay));
         req_stale  = 1'b0;
      end
      prev_waiting = mem_req_valid && !mem_req_ready;
      prev_addr    = mem_req_addr;
      inst_ready   = ($urandom_range(99) < p_iready);

      redirect_valid = redir;
      redirect_pc    = tgt;
      if (redir) begin
         if (pending) pend_stale = 1'b1;
         if (mem_req_valid && !hs) req_stale = 1'b1;
         fetch_pc     = tgt & ~64'd3;
         model_halted = 1'b0;
         exp_q.delete();
         buffered     = 0;
         chk_flush    = 1'b1;
         chk_valid    = 1'b0;
         chk_halt     = 1'b0;
      end
   endtask

   // monitor: retire the head on every decode handshake and compare with the queue
   always @(negedge clk) begin
      exp_t e;
      if (run && inst_valid && inst_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_inst", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e.pc);
            check("inst", {32'd0, inst}, {32'd0, e.w});
            buffered--;
            pops++;
         end
      end
   end

   initial begin
      int n;
      redir_on_rsp = 1'b0;
      ebreak_addr  = 64'h0000_0000_8000_000C;
      p_ready = 100; p_iready = 100; p_redir = 0; max_delay = 0;
      apply_reset();

      repeat (30) step();
      check("halt_reached", halted, 1);
      check("halt_inst_count", pops, 4);
      check("halt_drained", exp_q.size(), 0);

      ebreak_addr = 64'h1;
      force_redir = 1'b1; force_tgt = RESET_PC;
      repeat (20) step();
      check("restart_progress", (pops > 6), 1);

      p_iready = 0;
      repeat (20) step();
      check("stall_buffered", buffered, DEPTH);
      check("stall_no_req", mem_req_valid, 0);
      check("stall_inst_valid", inst_valid, 1);
      p_iready = 100;
      repeat (10) step();

      p_ready = 0;
      n = 0;
      while (!mem_req_valid && n < 20) begin step(); n++; end
      check("reqhold_reached", mem_req_valid, 1);
      repeat (5) step();
      p_ready = 100;
      repeat (10) step();

      max_delay = 4; p_iready = 0;
      n = 0;
      while (!(pending && pend_delay > 0 && buffered >= 1) && n < 60) begin step(); n++; end
      check("wait_state_reached", (n < 60), 1);
      force_redir = 1'b1; force_tgt = 64'h0000_0000_8000_1002;
      step();
      p_iready = 100; max_delay = 0;
      n = pops;
      repeat (20) step();
      check("redir_progress", (pops > n), 1);

      redir_on_rsp = 1'b1;
      repeat (30) step();
      redir_on_rsp = 1'b0;

      ebreak_addr = 64'h0000_0000_8000_0080;
      p_ready = 70; p_iready = 70; p_redir = 3; max_delay = 3;
      n = pops;
      repeat (3000) step();
      check("random_progress", (pops - n > 200), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
